// File: rtl/fifo_axis_pkg.sv
// Shared types and constants for the FIFO-to-AXI-Stream read adapter.
package fifo_axis_pkg;

  localparam int unsigned AXIS_CNT_W = 32;

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;

  // Number of words held in the output buffer for a given occupancy state.
  function automatic logic [1:0] occ_level(input occ_t occ);
    case (occ)
      OCC_ONE: return 2'd1;
      OCC_TWO: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/axis_skid_2e.sv
// Two-entry output buffer: capture writes the tail, pop retires the head.
module axis_skid_2e
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              pop,
  output occ_t              occ,
  output logic [DWIDTH-1:0] head_data
);

  occ_t              occ_q, occ_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [DWIDTH-1:0] mem_q [2];
  logic [DWIDTH-1:0] mem_d [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= OCC_EMPTY;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      mem_q  <= mem_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;

    case (occ_q)
      OCC_EMPTY: if (capture) occ_d = OCC_ONE;
      OCC_ONE: begin
        if (capture && !pop)      occ_d = OCC_TWO;
        else if (!capture && pop) occ_d = OCC_EMPTY;
      end
      OCC_TWO:   if (pop && !capture) occ_d = OCC_ONE;
      default:   occ_d = OCC_EMPTY;
    endcase

    if (pop) head_d = !head_q;
    if (capture) begin
      mem_d[tail_q] = wr_data;
      tail_d        = !tail_q;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_axis_master.sv
// Turns a one-cycle-latency FIFO read port into an AXI-Stream master with
// a 2-entry output buffer, fixed-length tlast generation and a beat counter.
module fifo_rd_axis_master
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned PKT_LEN = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  rst_i,
  output logic                  fifo_rd_en_o,
  input  logic [DWIDTH-1:0]     fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [AXIS_CNT_W-1:0] axis_rd_data_count
);

  localparam int unsigned BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned LAST_BEAT = (PKT_LEN > 0) ? PKT_LEN - 1 : 0;
  localparam logic [BEAT_W-1:0] LAST_BEAT_V = BEAT_W'(LAST_BEAT);

  occ_t                  occ;
  logic                  pop;
  logic [2:0]            level;
  logic                  inflight_q, inflight_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [AXIS_CNT_W-1:0] cnt_q, cnt_d;

  axis_skid_2e #(.DWIDTH(DWIDTH)) u_skid (
    .clk       (m_axis_aclk),
    .rst       (rst_i),
    .capture   (inflight_q),
    .wr_data   (fifo_rd_data_i),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_axis_tdata)
  );

  assign m_axis_tvalid = (occ != OCC_EMPTY);
  assign pop           = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge m_axis_aclk) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
    end
  end

  // Issue a read only if buffered plus in-flight words, after this cycle's pop, leave room.
  always_comb begin
    level        = 3'(occ_level(occ)) + 3'(inflight_q);
    fifo_rd_en_o = !rst_i && !fifo_empty_i && (level < (3'd2 + 3'(pop)));
    inflight_d   = fifo_rd_en_o;
    beat_d       = beat_q;
    cnt_d        = cnt_q + AXIS_CNT_W'(pop);
    if (pop) beat_d = (beat_q == LAST_BEAT_V) ? '0 : beat_q + BEAT_W'(1);
  end

  assign m_axis_tlast       = (PKT_LEN != 0) && m_axis_tvalid && (beat_q == LAST_BEAT_V);
  assign axis_rd_data_count = cnt_q;

endmodule

// File: tb/tb_fifo_rd_axis_master.sv
// Randomised bench: queue-level model of the FIFO, output buffer and stream,
// checked every cycle against two instances (PKT_LEN 16 and 4) fed identically.
module tb_fifo_rd_axis_master;
  import fifo_axis_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_i;
  logic          fifo_empty_i;
  logic          tready;
  logic [DW-1:0] fifo_rd_data_i;
  logic          rd_a, rd_b, tv_a, tv_b, tl_a, tl_b;
  logic [DW-1:0] td_a, td_b;
  logic [31:0]   cnt_a, cnt_b;

  always #5 clk = ~clk;

  fifo_rd_axis_master #(.DWIDTH(DW), .PKT_LEN(16)) u_a (
    .m_axis_aclk(clk), .rst_i(rst_i), .fifo_rd_en_o(rd_a), .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_empty_i(fifo_empty_i), .m_axis_tdata(td_a), .m_axis_tvalid(tv_a),
    .m_axis_tready(tready), .m_axis_tlast(tl_a), .axis_rd_data_count(cnt_a));

  fifo_rd_axis_master #(.DWIDTH(DW), .PKT_LEN(4)) u_b (
    .m_axis_aclk(clk), .rst_i(rst_i), .fifo_rd_en_o(rd_b), .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_empty_i(fifo_empty_i), .m_axis_tdata(td_b), .m_axis_tvalid(tv_b),
    .m_axis_tready(tready), .m_axis_tlast(tl_b), .axis_rd_data_count(cnt_b));

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] buf_m[$];
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] got_q[$];
  bit            inflight_m, force_empty, rst_last;
  int unsigned   beats_m;
  int            vectors, errors;
  bit            s_rd, s_valid, s_pop;
  logic [31:0]   s_cnt;
  int            reads_n, pop_idx;
  logic [15:0]   mask_a, mask_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    reads_n = 0;
    pop_idx = 0;
    mask_a  = '0;
    mask_b  = '0;
  endtask

  // One clock cycle: compare at negedge, advance the model at posedge, then the FIFO responds.
  task automatic step();
    bit exp_valid, pop_m, exp_rd;
    fifo_empty_i = (src_q.size() == 0) || force_empty;
    @(negedge clk);
    exp_valid = (buf_m.size() != 0);
    pop_m     = exp_valid && tready && !rst_i;
    exp_rd    = !rst_i && !fifo_empty_i &&
                (buf_m.size() + int'(inflight_m) - int'(pop_m) < 2);
    chk("rd_en_a", rd_a, exp_rd);
    chk("rd_en_b", rd_b, exp_rd);
    if (!rst_i || rst_last) begin
      chk("tvalid_a", tv_a, exp_valid);
      chk("tvalid_b", tv_b, exp_valid);
      if (exp_valid) begin
        chk("tdata_a", td_a, buf_m[0]);
        chk("tdata_b", td_b, buf_m[0]);
      end
      chk("tlast_a", tl_a, exp_valid && (beats_m % 16 == 15));
      chk("tlast_b", tl_b, exp_valid && (beats_m % 4 == 3));
      chk("count_a", cnt_a, beats_m);
      chk("count_b", cnt_b, beats_m);
      chk("occ_inv", (int'(occ_level(u_a.occ)) + int'(u_a.inflight_q)) <= 2, 1);
    end
    if (rst_last) chk("reset_tdata", td_a, 0);
    s_rd    = rd_a;
    s_valid = tv_a;
    s_pop   = pop_m;
    s_cnt   = cnt_a;
    if (rd_a) reads_n++;
    if (pop_m) begin
      got_q.push_back(td_a);
      if (pop_idx < 16) begin
        mask_a[pop_idx] = tl_a;
        mask_b[pop_idx] = tl_b;
      end
      pop_idx++;
    end
    @(posedge clk);
    rst_last = rst_i;
    if (rst_i) begin
      buf_m.delete();
      inflight_m = 0;
      beats_m    = 0;
    end else begin
      if (pop_m) begin
        void'(buf_m.pop_front());
        beats_m++;
      end
      if (inflight_m) buf_m.push_back(fifo_rd_data_i);
      inflight_m = exp_rd;
    end
    #1;
    if (s_rd && src_q.size() != 0) fifo_rd_data_i = src_q.pop_front();
    else                           fifo_rd_data_i = DW'($urandom);
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    tready      = 1'b0;
    force_empty = 1'b0;
    step();
    rst_i = 1'b0;
    clear_logs();
  endtask

  task automatic load(input int n, input int base, input bit rnd);
    logic [DW-1:0] w;
    src_q.delete();
    sent_q.delete();
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom) : DW'(base + i);
      src_q.push_back(w);
      sent_q.push_back(w);
    end
  endtask

  task automatic drain(input int n, input int budget, input bit rnd_ready, input bit rnd_empty,
                       input bit toggle);
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (toggle)         force_empty = ~force_empty;
      else if (rnd_empty) force_empty = ($urandom_range(0, 3) == 0);
      else                force_empty = 1'b0;
      step();
    end
    force_empty = 1'b0;
    chk("drain_count", got_q.size(), n);
  endtask

  task automatic check_order(input string name, input int skip);
    for (int i = 0; i < got_q.size() && i + skip < sent_q.size(); i++)
      chk(name, got_q[i], sent_q[i + skip]);
  endtask

  initial begin
    int first_v;
    clk            = 1'b0;
    vectors        = 0;
    errors         = 0;
    inflight_m     = 0;
    rst_last       = 0;
    beats_m        = 0;
    fifo_rd_data_i = '0;
    rst_i          = 1'b1;
    tready         = 1'b0;
    force_empty    = 1'b0;
    step();
    step();

    // Prime: preloaded 0x01..0x05, tready high from release.
    load(5, 1, 0);
    rst_i = 1'b0;
    tready = 1'b1;
    clear_logs();
    first_v = -1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) chk("prime_rd_c0", s_rd, 1);
      if (c >= 2 && c <= 6) chk("prime_beat_cycle", s_pop, 1);
      if (s_valid && first_v < 0) first_v = c;
    end
    chk("prime_first_valid", first_v, 2);
    chk("prime_words", got_q.size(), 5);
    for (int i = 0; i < got_q.size(); i++) chk("prime_data", got_q[i], i + 1);
    chk("prime_count", cnt_a, 5);
    chk("prime_tlast16", mask_a, 0);

    // Backpressure mid-stream.
    do_reset();
    load(40, 0, 1);
    tready = 1'b1;
    for (int c = 0; c < 15; c++) step();
    reads_n = 0;
    tready  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp_stall_valid", s_valid, 1);
    end
    chk("bp_stall_reads", reads_n <= 2, 1);
    tready = 1'b1;
    step();
    chk("bp_resume_rd", s_rd, 1);
    chk("bp_resume_pop1", s_pop, 1);
    step();
    chk("bp_resume_pop2", s_pop, 1);
    drain(40, 200, 0, 0, 0);
    check_order("bp_order", 0);

    // Packet boundaries with random tready.
    do_reset();
    load(12, 0, 1);
    drain(12, 300, 1, 0, 0);
    chk("pkt_tlast4", mask_b[11:0], 12'h888);
    chk("pkt_tlast16", mask_a, 0);
    check_order("pkt_order", 0);

    // FIFO empty flag toggling every cycle.
    do_reset();
    load(30, 0, 1);
    drain(30, 300, 0, 0, 1);
    check_order("toggle_order", 0);

    // Random soak.
    do_reset();
    load(200, 0, 1);
    drain(200, 3000, 1, 1, 0);
    check_order("soak_order", 0);

    // Reset while the buffer holds a word and a read is returning.
    do_reset();
    load(20, 8'h40, 0);
    tready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    tready = 1'b0;
    for (int c = 0; c < 4; c++) step();
    tready = 1'b1;
    step();
    chk("mid_pre_words", got_q.size(), 5);
    tready = 1'b0;
    rst_i  = 1'b1;
    step();
    rst_i = 1'b0;
    clear_logs();
    step();
    chk("mid_tvalid", s_valid, 0);
    chk("mid_count", s_cnt, 0);
    drain(13, 300, 1, 0, 0);
    chk("mid_first_word", got_q.size() > 0 ? 32'(got_q[0]) : 32'hFFFF_FFFF, 8'h47);
    check_order("mid_order", 7);
    chk("mid_tlast4", mask_b[12:0], 13'h0888);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
